// File: rtl/ssd_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
//   state_e   : binary-to-BCD converter FSM states
//   bcd_t     : one BCD digit
//   bcd4_t    : four packed BCD digits, digit 0 in bits [3:0]
//   add3_all  : double-dabble correction step (+3 on every nibble >= 5)
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_e;

  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned DIGIT_W  = 4;

  typedef logic [DIGIT_W-1:0]          bcd_t;
  typedef logic [N_DIGITS*DIGIT_W-1:0] bcd4_t;

  // Apply the add-3 correction to every BCD nibble ahead of a shift.
  function automatic bcd4_t add3_all(input bcd4_t v);
    bcd4_t r;
    bcd_t  n;
    r = v;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      n = v[i*DIGIT_W +: DIGIT_W];
      r[i*DIGIT_W +: DIGIT_W] = (n >= 4'd5) ? bcd_t'(n + 4'd3) : n;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
//   clk, rst : clock, synchronous active-high reset
//   bin_in   : binary value, captured on load while idle
//   load     : start strobe, ignored unless idle
//   busy     : conversion in progress (including the update cycle)
//   done     : one-cycle pulse while bcd holds the finished result
//   bcd      : BCD accumulator, valid when done=1
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int unsigned BIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int unsigned CNT_W = $clog2(BIN_W);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state and datapath: one add-3/shift iteration per CONV cycle.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {add3_all(bcd_q), bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        // done is registered, so raise it on the way into UPDATE.
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = UPDATE;
          done_d  = 1'b1;
        end
      end
      UPDATE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Binary value to 4-digit multiplexed common-anode display feeder.
//   clk, rst   : clock, synchronous active-high reset
//   bin_in     : binary value to display, captured on load
//   load       : one-cycle strobe, accepted only when busy=0
//   busy       : conversion in progress
//   conv_done  : one-cycle pulse when the display register updates
//   digit_out  : BCD digit of the current slot (decoder input)
//   an_out     : active-low anode enables, bit k = slot k (slot 0 = ones)
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned BIN_W       = 8,
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             busy,
  output logic             conv_done,
  output logic [3:0]       digit_out,
  output logic [3:0]       an_out
);

  localparam int unsigned REF_W = $clog2(REFRESH_DIV);

  logic [15:0]      conv_bcd;
  logic [15:0]      disp_q, disp_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic [1:0]       slot_q, slot_d;
  logic             z1, z2, z3;
  logic             blank;

  bin2bcd_seq #(
    .BIN_W (BIN_W)
  ) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .bin_in (bin_in),
    .load   (load),
    .busy   (busy),
    .done   (conv_done),
    .bcd    (conv_bcd)
  );

  // Display register load and free-running slot scanner.
  always_comb begin
    disp_d = conv_done ? conv_bcd : disp_q;
    ref_d  = ref_q + 1'b1;
    slot_d = slot_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d  = '0;
      slot_d = slot_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= '0;
      ref_q  <= '0;
      slot_q <= '0;
    end else begin
      disp_q <= disp_d;
      ref_q  <= ref_d;
      slot_q <= slot_d;
    end
  end

  // zK: digits K..3 are all zero, i.e. slot K is a leading zero.
  always_comb begin
    z3 = (disp_q[15:12] == 4'd0);
    z2 = z3 && (disp_q[11:8] == 4'd0);
    z1 = z2 && (disp_q[7:4] == 4'd0);
  end

  // Slot decode: digit select plus leading-zero anode suppression.
  always_comb begin
    digit_out = disp_q[3:0];
    blank     = 1'b0;
    case (slot_q)
      2'd0: begin
        digit_out = disp_q[3:0];
        blank     = 1'b0;
      end
      2'd1: begin
        digit_out = disp_q[7:4];
        blank     = z1;
      end
      2'd2: begin
        digit_out = disp_q[11:8];
        blank     = z2;
      end
      default: begin
        digit_out = disp_q[15:12];
        blank     = z3;
      end
    endcase
    an_out = (BLANK_LZ && blank) ? 4'b1111 : ~(4'b0001 << slot_q);
  end

endmodule
